// File: rtl/uart_rx_cmd.sv
// uart_rx_cmd: 16x-oversampled UART receiver with an ASCII "C<hex>" decoder
// that selects the ADC channel driven onto ch_sel.
//
// Handshake: rx_done, frame_err, ch_update and cmd_err are single-cycle strobes
// with no back-pressure; rx_data and ch_sel are valid whenever their strobe is
// high and hold their value until the next strobe.
module uart_rx_cmd #(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int DVSR     = 326,
    parameter int DVSR_BIT = 9,
    parameter int NUM_CH   = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic [3:0] ch_sel,
    output logic       ch_update,
    output logic       cmd_err,
    output logic [1:0] rx_state_dbg,
    output logic       cmd_state_dbg
);

    localparam int NW = $clog2(DBIT);
    localparam logic [NW-1:0]       N_LAST  = NW'(DBIT - 1);
    localparam logic [3:0]          SB_LAST = 4'(SB_TICK - 1);
    localparam logic [DVSR_BIT-1:0] DV_LAST = DVSR_BIT'(DVSR - 1);
    localparam logic [4:0]          NCH     = 5'(NUM_CH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic {WAIT_C, WAIT_D} cmd_state_t;

    logic                sync1, rx_s, armed;
    logic [1:0]          sync_fill;
    logic [DVSR_BIT-1:0] dcnt;
    logic                tick;

    // The reset value of the synchronizer is not evidence of an idle line, so
    // arming waits until both stages hold real samples of rx.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= 1'b1;
            rx_s      <= 1'b1;
            sync_fill <= 2'b00;
            armed     <= 1'b0;
        end else begin
            sync1     <= rx;
            rx_s      <= sync1;
            sync_fill <= {sync_fill[0], 1'b1};
            if (sync_fill[1] && rx_s) armed <= 1'b1;
        end
    end

    assign tick = (dcnt == DV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) dcnt <= '0;
        else     dcnt <= tick ? '0 : dcnt + 1'b1;
    end

    rx_state_t       rx_state, rx_state_n;
    logic [3:0]      s_reg, s_n;
    logic [NW-1:0]   n_reg, n_n;
    logic [7:0]      b_reg, b_n;
    logic            done_n, ferr_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state  <= IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_state  <= rx_state_n;
            s_reg     <= s_n;
            n_reg     <= n_n;
            b_reg     <= b_n;
            rx_done   <= done_n;
            frame_err <= ferr_n;
            if (done_n) rx_data <= b_reg;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        s_n        = s_reg;
        n_n        = n_reg;
        b_n        = b_reg;
        case (rx_state)
            IDLE: if (armed && !rx_s) begin
                rx_state_n = START;
                s_n        = '0;
            end
            START: if (tick) begin
                if (s_reg == 4'd7) begin
                    if (!rx_s) begin
                        rx_state_n = DATA;
                        s_n        = '0;
                        n_n        = '0;
                    end else begin
                        rx_state_n = IDLE;
                    end
                end else begin
                    s_n = s_reg + 4'd1;
                end
            end
            DATA: if (tick) begin
                if (s_reg == 4'd15) begin
                    s_n = '0;
                    b_n = {rx_s, b_reg[7:1]};
                    if (n_reg == N_LAST) rx_state_n = STOP;
                    else                 n_n = n_reg + 1'b1;
                end else begin
                    s_n = s_reg + 4'd1;
                end
            end
            STOP: if (tick) begin
                if (s_reg == SB_LAST) rx_state_n = IDLE;
                else                  s_n = s_reg + 4'd1;
            end
            default: rx_state_n = IDLE;
        endcase
    end

    always_comb begin
        done_n = 1'b0;
        ferr_n = 1'b0;
        if (rx_state == STOP && tick && s_reg == SB_LAST) begin
            done_n = rx_s;
            ferr_n = !rx_s;
        end
    end

    cmd_state_t cmd_state, cmd_state_n;
    logic       hex_ok, ch_ok, upd_n, cerr_n;
    logic [3:0] hex_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_state <= WAIT_C;
            ch_sel    <= '0;
            ch_update <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            cmd_state <= cmd_state_n;
            ch_update <= upd_n;
            cmd_err   <= cerr_n;
            if (upd_n) ch_sel <= hex_v;
        end
    end

    always_comb begin
        cmd_state_n = cmd_state;
        if (rx_done || frame_err) begin
            case (cmd_state)
                WAIT_C:  if (rx_done && (rx_data == 8'h43 || rx_data == 8'h63))
                             cmd_state_n = WAIT_D;
                WAIT_D:  cmd_state_n = WAIT_C;
                default: cmd_state_n = WAIT_C;
            endcase
        end
    end

    always_comb begin
        hex_ok = 1'b1;
        hex_v  = '0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39)      hex_v = 4'(rx_data - 8'h30);
        else if (rx_data >= 8'h41 && rx_data <= 8'h46) hex_v = 4'(rx_data - 8'h37);
        else if (rx_data >= 8'h61 && rx_data <= 8'h66) hex_v = 4'(rx_data - 8'h57);
        else                                           hex_ok = 1'b0;
        ch_ok  = hex_ok && ({1'b0, hex_v} < NCH);
        upd_n  = (cmd_state == WAIT_D) && rx_done && ch_ok;
        cerr_n = (cmd_state == WAIT_D) && (frame_err || (rx_done && !ch_ok));
    end

    assign rx_state_dbg  = rx_state;
    assign cmd_state_dbg = cmd_state;

endmodule

// File: tb/tb_uart_rx_cmd.sv
// Bench for uart_rx_cmd: drives serial frames, predicts the strobe/event stream
// from the byte sequence, and compares it with what the DUT emits.
module tb_uart_rx_cmd;

    localparam int DVSR   = 5;
    localparam int BIT    = 16 * DVSR;
    localparam int NUM_CH = 13;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done, frame_err, ch_update, cmd_err;
    logic [3:0] ch_sel;
    logic [1:0] rx_state_dbg;
    logic       cmd_state_dbg;

    int errors = 0;
    int checks = 0;

    // Event word: {kind[3:0], latency[3:0], ch_sel[3:0], rx_data[7:0]}
    // kind 1=rx_done 2=frame_err 3=ch_update 4=cmd_err, E/F = illegal overlap.
    logic [19:0] exp_q[$];
    logic [19:0] obs_q[$];

    logic [3:0] exp_ch;
    logic [7:0] exp_data;
    bit         wait_d;

    uart_rx_cmd #(
        .DBIT(8), .SB_TICK(16), .DVSR(DVSR), .DVSR_BIT(3), .NUM_CH(NUM_CH)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .rx_data(rx_data), .rx_done(rx_done), .frame_err(frame_err),
        .ch_sel(ch_sel), .ch_update(ch_update), .cmd_err(cmd_err),
        .rx_state_dbg(rx_state_dbg), .cmd_state_dbg(cmd_state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    // monitor
    int cyc = 0;
    int last_rx_cyc = 0;
    always @(negedge clk) begin
        int lat;
        cyc++;
        lat = cyc - last_rx_cyc;
        if (lat > 15) lat = 15;
        if (rx_done && frame_err) obs_q.push_back({4'hF, 16'h0});
        else if (rx_done)   begin obs_q.push_back({4'd1, 4'd0, ch_sel, rx_data}); last_rx_cyc = cyc; end
        else if (frame_err) begin obs_q.push_back({4'd2, 4'd0, ch_sel, rx_data}); last_rx_cyc = cyc; end
        if (ch_update && cmd_err) obs_q.push_back({4'hE, 16'h0});
        else if (ch_update) obs_q.push_back({4'd3, 4'(lat), ch_sel, rx_data});
        else if (cmd_err)   obs_q.push_back({4'd4, 4'(lat), ch_sel, rx_data});
    end

    // reference model: command parser over the byte stream
    task automatic model_frame(input logic [7:0] d, input bit good);
        int v;
        bit hex;
        if (!good) begin
            exp_q.push_back({4'd2, 4'd0, exp_ch, exp_data});
            if (wait_d) exp_q.push_back({4'd4, 4'd1, exp_ch, exp_data});
            wait_d = 0;
            return;
        end
        exp_data = d;
        exp_q.push_back({4'd1, 4'd0, exp_ch, d});
        if (!wait_d) begin
            wait_d = (d == "C" || d == "c");
            return;
        end
        wait_d = 0;
        hex = 1;
        v = 0;
        if (d >= "0" && d <= "9")      v = d - "0";
        else if (d >= "A" && d <= "F") v = d - "A" + 10;
        else if (d >= "a" && d <= "f") v = d - "a" + 10;
        else hex = 0;
        if (hex && v < NUM_CH) begin
            exp_ch = 4'(v);
            exp_q.push_back({4'd3, 4'd1, exp_ch, d});
        end else begin
            exp_q.push_back({4'd4, 4'd1, exp_ch, d});
        end
    endtask

    // driver tasks
    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit good);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (good) begin
            drive_bit(1'b1);
        end else begin
            rx = 1'b0;
            repeat (12 * DVSR) @(negedge clk);
            rx = 1'b1;
            repeat (4 * DVSR) @(negedge clk);
        end
    endtask

    task automatic tx(input logic [7:0] d, input bit good);
        model_frame(d, good);
        send_frame(d, good);
    endtask

    // scoreboard
    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_events(input string tag);
        logic [19:0] o, e;
        checks++;
        assert (obs_q.size() === exp_q.size()) else begin
            errors++;
            $error("FAIL %s event_count: observed=%0d expected=%0d", tag, obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 20'hDEAD0;
            checks++;
            assert (o === e) else begin
                errors++;
                $error("FAIL %s event: observed=%h expected=%h", tag, o, e);
            end
        end
        obs_q.delete();
    endtask

    task automatic settle(input string tag);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check_events(tag);
        check_val({tag, "_ch_sel"}, {4'h0, ch_sel}, {4'h0, exp_ch});
        check_val({tag, "_rx_data"}, rx_data, exp_data);
    endtask

    initial begin
        string hx = "0123456789ABCDEFabcdef";
        logic [7:0] d;
        bit good;

        exp_ch = '0; exp_data = '0; wait_d = 0;

        // reset with the line held low
        rst = 1'b1;
        rx  = 1'b0;
        repeat (5) @(negedge clk);
        check_val("rst_rx_data", rx_data, 8'h00);
        check_val("rst_ch_sel", {4'h0, ch_sel}, 8'h00);
        check_val("rst_rx_done", {7'h0, rx_done}, 8'h00);
        check_val("rst_frame_err", {7'h0, frame_err}, 8'h00);
        check_val("rst_ch_update", {7'h0, ch_update}, 8'h00);
        check_val("rst_cmd_err", {7'h0, cmd_err}, 8'h00);
        rst = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        check_events("low_after_reset");
        drive_bit(1'b1);

        tx(8'h55, 1'b1);
        settle("byte_55");

        tx("C", 1'b1);
        tx("7", 1'b1);
        settle("cmd_c7");

        tx("c", 1'b1);
        tx("C", 1'b1);
        settle("cmd_cC");

        tx("C", 1'b1);
        tx("D", 1'b1);
        settle("cmd_cD_range");

        tx(8'hA3, 1'b0);
        settle("ferr_idle");

        tx("C", 1'b1);
        settle("cmd_c_prefix");
        tx(8'hA3, 1'b0);
        settle("ferr_after_c");

        tx("4", 1'b1);
        settle("digit_in_wait_c");

        // start-bit glitch shorter than half a bit
        rx = 1'b0;
        repeat (4 * DVSR) @(negedge clk);
        settle("glitch");

        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 4))
                0:       d = "C";
                1:       d = "c";
                2, 3:    d = hx[$urandom_range(0, 21)];
                default: d = 8'($urandom_range(0, 255));
            endcase
            good = ($urandom_range(0, 7) != 0);
            tx(d, good);
            settle("random");
        end

        // reset mid-DATA of a 'C' + '5' stream
        tx("C", 1'b1);
        check_events("abort_prefix");
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rst = 1'b1;
        #1;
        check_val("abort_ch_sel", {4'h0, ch_sel}, 8'h00);
        check_val("abort_rx_data", rx_data, 8'h00);
        check_val("abort_pulses", {4'h0, rx_done, frame_err, ch_update, cmd_err}, 8'h00);
        exp_ch = '0; exp_data = '0; wait_d = 0;
        rx = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        repeat (2 * BIT) @(negedge clk);
        check_events("abort_quiet");

        tx("C", 1'b1);
        tx("3", 1'b1);
        settle("after_abort_c3");
        check_val("final_ch3", {4'h0, ch_sel}, 8'h03);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
